alu_seq: RTL

- Parametrised, registered successor to the combinational datapath ALU.
- Adds carry-in ops (ADC/SBC), negative and overflow flags, a persistent flag register, and multi-cycle unsigned MUL/DIV through an iterative unit.
- Sits between the register file and the control unit.
- Uses a valid/ready handshake so the control FSM can stall on long ops.

---
 rtl/alu_seq_pkg.sv | 43 ++++
 rtl/alu_muldiv_iter.sv | 99 +++++++++
 rtl/alu_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the registered ALU: op encodings, flag register layout
// and the sequencer state.
package alu_seq_pkg;

    // Original datapath ops keep their values; ADC/SBC/MUL/DIV are appended.
    // Encodings 16..31 are undefined and complete as a no-op.
    typedef enum logic [4:0] {
        ALU_NOP = 5'd0,
        ALU_THR = 5'd1,
        ALU_ADD = 5'd2,
        ALU_SUB = 5'd3,
        ALU_AND = 5'd4,
        ALU_OR  = 5'd5,
        ALU_XOR = 5'd6,
        ALU_NOT = 5'd7,
        ALU_SHL = 5'd8,
        ALU_SHR = 5'd9,
        ALU_ROL = 5'd10,
        ALU_ROR = 5'd11,
        ALU_ADC = 5'd12,
        ALU_SBC = 5'd13,
        ALU_MUL = 5'd14,
        ALU_DIV = 5'd15
    } alu_op_e;

    typedef struct packed {
        logic alu_carry;
        logic alu_zero;
        logic alu_negative;
        logic alu_overflow;
    } alu_flag_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_muldiv(input alu_op_e o);
        return (o == ALU_MUL) || (o == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) / divider (restoring) sharing a
// single adder. One iteration per clock, W iterations per operation. The
// next-state values are exposed combinationally so the caller can capture
// the final product/quotient on the same edge that performs the last step.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic          busy;
    logic          div_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  hi_q;   // partial product high half / partial remainder
    logic [W-1:0]  lo_q;   // multiplier bits / dividend-then-quotient bits
    logic [CW-1:0] cnt;

    logic [W:0]    add_x;
    logic [W:0]    add_y;
    logic          add_cin;
    logic [W+1:0]  add_sum;
    logic          fits;
    logic [W-1:0]  hi_n;
    logic [W-1:0]  lo_n;

    // Shared adder: multiply adds B when the current multiplier bit is set,
    // divide subtracts B from the shifted remainder (two's complement).
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (div_q) begin
            add_x   = {hi_q, lo_q[W-1]};
            add_y   = ~{1'b0, b_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, hi_q};
            add_y   = lo_q[0] ? {1'b0, b_q} : '0;
            add_cin = 1'b0;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(W+1){1'b0}}, add_cin};
    end

    // Next iteration values; a carry out of the subtract means no borrow.
    always_comb begin
        fits = add_sum[W+1];
        if (div_q) begin
            hi_n = fits ? add_sum[W-1:0] : add_x[W-1:0];
            lo_n = {lo_q[W-2:0], fits};
        end else begin
            hi_n = add_sum[W:1];
            lo_n = {add_sum[0], lo_q[W-1:1]};
        end
    end

    assign done = busy && (cnt == LAST);
    assign lo   = lo_n;
    assign hi   = hi_n;

    // Operand load on start, then one iteration per cycle until the count ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div_q <= is_div;
            b_q   <= b;
            hi_q  <= '0;
            lo_q  <= a;
            cnt   <= '0;
        end else if (busy) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            cnt  <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with a persistent flag register and valid/ready request
// interface. Single-cycle ops complete one cycle after accept; MUL/DIV run
// through the iterative unit and complete W+1 cycles after accept.
//
// Handshake: a request is accepted on any clk edge where in_valid and
// in_ready are both high; op and operands are sampled only then. in_ready is
// low only while a MUL/DIV iterates, so a requester must hold in_valid.
// out_valid is a one-cycle pulse marking that result/result_hi/flag were
// just written (or, for no-op encodings, deliberately left unchanged).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter bit ENABLE_MULDIV  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  alu_op_e                   op,
    input  logic [DATA_BUS_WIDTH-1:0] register1,
    input  logic [DATA_BUS_WIDTH-1:0] register2,
    output logic                      out_valid,
    output logic [DATA_BUS_WIDTH-1:0] result,
    output logic [DATA_BUS_WIDTH-1:0] result_hi,
    output alu_flag_t                 flag,
    output alu_state_e                fsm_state
);

    localparam int W = DATA_BUS_WIDTH;

    alu_state_e state;
    logic       accept;
    logic       take_md;
    logic       md_start;
    logic       md_done;
    logic [W-1:0] md_lo;
    logic [W-1:0] md_hi;
    logic       md_div;
    logic       md_bzero;

    logic [W:0]   add_sum;
    logic [W:0]   sub_diff;
    logic [W-1:0] sc_res;
    logic         sc_c;
    logic         sc_v;
    logic         sc_upd;

    assign in_ready  = (state != BUSY);
    assign out_valid = (state == DONE);
    assign fsm_state = state;
    assign accept    = in_valid && in_ready;
    assign take_md   = ENABLE_MULDIV && is_muldiv(op);
    assign md_start  = accept && take_md;

    // Single-cycle ops; carry-in is the flag register as it stood before accept.
    always_comb begin
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_upd   = 1'b1;
        add_sum  = {1'b0, register1} + {1'b0, register2}
                 + {{W{1'b0}}, (op == ALU_ADC) && flag.alu_carry};
        sub_diff = {1'b0, register1} - {1'b0, register2}
                 - {{W{1'b0}}, (op == ALU_SBC) && flag.alu_carry};
        case (op)
            ALU_THR: sc_res = register1;
            ALU_ADD, ALU_ADC: begin
                sc_res = add_sum[W-1:0];
                sc_c   = add_sum[W];
                sc_v   = (register1[W-1] == register2[W-1]) &&
                         (add_sum[W-1] != register1[W-1]);
            end
            ALU_SUB, ALU_SBC: begin
                sc_res = sub_diff[W-1:0];
                sc_c   = sub_diff[W];
                sc_v   = (register1[W-1] != register2[W-1]) &&
                         (sub_diff[W-1] != register1[W-1]);
            end
            ALU_AND: sc_res = register1 & register2;
            ALU_OR:  sc_res = register1 | register2;
            ALU_XOR: sc_res = register1 ^ register2;
            ALU_NOT: sc_res = ~register1;
            ALU_SHL: begin
                sc_res = {register1[W-2:0], 1'b0};
                sc_c   = register1[W-1];
            end
            ALU_SHR: begin
                sc_res = {1'b0, register1[W-1:1]};
                sc_c   = register1[0];
            end
            ALU_ROL: sc_res = {register1[W-2:0], register1[W-1]};
            ALU_ROR: sc_res = {register1[0], register1[W-1:1]};
            default: sc_upd = 1'b0;
        endcase
    end

    generate
        if (ENABLE_MULDIV) begin : g_muldiv
            alu_muldiv_iter #(.W(W)) u_iter (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (md_start),
                .is_div (op == ALU_DIV),
                .a      (register1),
                .b      (register2),
                .done   (md_done),
                .lo     (md_lo),
                .hi     (md_hi)
            );
        end else begin : g_no_muldiv
            assign md_done = 1'b0;
            assign md_lo   = '0;
            assign md_hi   = '0;
        end
    endgenerate

    // Sequencer: state plus the result/flag registers written on DONE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            result    <= '0;
            result_hi <= '0;
            flag      <= '0;
            md_div    <= 1'b0;
            md_bzero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (take_md) begin
                            state    <= BUSY;
                            md_div   <= (op == ALU_DIV);
                            md_bzero <= (register2 == '0);
                        end else begin
                            state <= DONE;
                            if (sc_upd) begin
                                result            <= sc_res;
                                result_hi         <= '0;
                                flag.alu_carry    <= sc_c;
                                flag.alu_zero     <= (sc_res == '0);
                                flag.alu_negative <= sc_res[W-1];
                                flag.alu_overflow <= sc_v;
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        state             <= DONE;
                        result            <= md_lo;
                        result_hi         <= md_hi;
                        flag.alu_carry    <= md_div ? 1'b0 : (|md_hi);
                        flag.alu_zero     <= (md_lo == '0);
                        flag.alu_negative <= md_lo[W-1];
                        flag.alu_overflow <= md_div && md_bzero;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
